// File: rtl/alu_sched_pkg.sv
// Shared types for the two-requester ALU scheduler: FSM state, funct3 codes, request payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        ctrl;   // instruction bit 30: sub / arithmetic right shift
  } req_t;

endpackage

// File: rtl/alu.sv
// Shared 32-bit integer ALU; comparisons arrive precomputed on lt_i/ltu_i.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i, op_i (funct3), ctrl_i (sub/sra), lt_i, ltu_i in; result_o, zero_o, neg_o out.
module alu
  import alu_sched_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  input  logic        ctrl_i,
  input  logic        lt_i,
  input  logic        ltu_i,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        neg_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      F3_ADD:  result_o = ctrl_i ? (a_i - b_i) : (a_i + b_i);
      F3_SLL:  result_o = a_i << shamt;
      F3_SLT:  result_o = {31'b0, lt_i};
      F3_SLTU: result_o = {31'b0, ltu_i};
      F3_XOR:  result_o = a_i ^ b_i;
      F3_SR:   result_o = ctrl_i ? 32'($signed(a_i) >>> shamt) : (a_i >> shamt);
      F3_OR:   result_o = a_i | b_i;
      F3_AND:  result_o = a_i & b_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == 32'd0);
  assign neg_o  = result_o[31];

endmodule

// File: rtl/alu_cmp32.sv
// Signed and unsigned 32-bit less-than comparator feeding the ALU set-less-than ops.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i operands; lt_o = signed a<b; ltu_o = unsigned a<b.
module alu_cmp32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        lt_o,
  output logic        ltu_o
);

  assign lt_o  = $signed(a_i) < $signed(b_i);
  assign ltu_o = a_i < b_i;

endmodule

// File: rtl/alu_sched.sv
// Two-requester scheduler in front of the shared ALU: arbitrate, register operands, execute, return result+id.
// Latency: request accepted in cycle N, response valid in cycle N+2; one op in flight, issue interval >= 3.
// Backpressure: rsp_ready low holds RESP with all rsp_* stable and both request readies low.
// Ports: clk, rst_n (async active-low); reqN_valid/ready/a/b/op/ctrl per requester; rsp_valid/ready/id/result/zero/neg.
// Build option: ALU_SCHED_RR_EN selects round-robin; otherwise requester PRIO_INIT wins fixed priority.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  input  logic        req1_ctrl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_neg
);

  state_e      state_q, state_d;
  req_t        req0_pl, req1_pl, opnd_q;
  logic        id_q;
  logic        prio;
  logic        gnt0, gnt1, accept;
  logic        lt, ltu, alu_zero, alu_neg;
  logic [31:0] alu_res;
  logic [31:0] rsp_result_q;
  logic        rsp_id_q, rsp_zero_q, rsp_neg_q;

  assign req0_pl = '{a: req0_a, b: req0_b, op: req0_op, ctrl: req0_ctrl};
  assign req1_pl = '{a: req1_a, b: req1_b, op: req1_op, ctrl: req1_ctrl};

  // prio names the requester that wins a tie; a lone valid always wins.
  assign gnt1 = req1_valid & (~req0_valid | prio);
  assign gnt0 = req0_valid & ~gnt1;

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt0 | gnt1) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  // Readies are gated by rst_n so they read 0 for the whole time reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready = rst_n & gnt0;
        req1_ready = rst_n & gnt1;
      end
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = req0_ready | req1_ready;

`ifdef ALU_SCHED_RR_EN
  logic prio_q;
  // After a grant the other requester gets the tie-break.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prio_q <= PRIO_INIT;
    else if (accept) prio_q <= ~gnt1;
  end
  assign prio = prio_q;
`else
  assign prio = PRIO_INIT;
`endif

  // ---- operand and response registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q       <= '0;
      id_q         <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_neg_q    <= 1'b0;
    end else begin
      if (accept) begin
        opnd_q <= gnt1 ? req1_pl : req0_pl;
        id_q   <= gnt1;
      end
      if (state_q == ST_EXEC) begin
        rsp_result_q <= alu_res;
        rsp_id_q     <= id_q;
        rsp_zero_q   <= alu_zero;
        rsp_neg_q    <= alu_neg;
      end
    end
  end

  alu_cmp32 u_cmp (
    .a_i   (opnd_q.a),
    .b_i   (opnd_q.b),
    .lt_o  (lt),
    .ltu_o (ltu)
  );

  alu u_alu (
    .a_i      (opnd_q.a),
    .b_i      (opnd_q.b),
    .op_i     (opnd_q.op),
    .ctrl_i   (opnd_q.ctrl),
    .lt_i     (lt),
    .ltu_i    (ltu),
    .result_o (alu_res),
    .zero_o   (alu_zero),
    .neg_o    (alu_neg)
  );

  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_neg    = rsp_neg_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: reset values, ALU ops via both requesters, arbitration, backpressure, mid-op reset.
// Latency: checks response appears exactly two cycles after the accept cycle.
// Backpressure: holds rsp_ready low and checks outputs are frozen and readies low.
module tb_alu_sched;
  import alu_sched_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_ctrl;
  logic        req1_valid, req1_ready, req1_ctrl;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_neg;
  logic [31:0] rsp_result;

  int checks;
  int failures;

  alu_sched #(.PRIO_INIT(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .req1_ctrl  (req1_ctrl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_neg    (rsp_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic ctrl);
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op; req1_ctrl = ctrl; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_ctrl = ctrl; req0_valid = 1'b1;
    end
  endtask

  // Waits (bounded) until requester id is granted, then lets the handshake edge pass.
  task automatic wait_grant(input string tag, input bit id);
    int n;
    n = 0;
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_grant_timeout"}, 32'(n < 20), 32'd1);
    tick();
  endtask

  // One complete transaction on requester id with a hand-computed expected result.
  task automatic do_req(input string tag, input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic ctrl, input logic [31:0] exp_res,
                        input logic exp_neg, input logic exp_zero);
    drive(id, a, b, op, ctrl);
    wait_grant(tag, id);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({tag, "_exec_vld"}, 32'(rsp_valid), 32'd0);
    tick();
    chk({tag, "_rsp_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_result"}, rsp_result, exp_res);
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    chk({tag, "_neg"}, 32'(rsp_neg), 32'(exp_neg));
    chk({tag, "_zero"}, 32'(rsp_zero), 32'(exp_zero));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_idle_vld"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [31:0] held_res;
  logic        held_id;
  bit          seen1;
  bit          exp_ids [4];

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0; req0_ctrl = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0; req1_ctrl = 1'b0;

    // Reset values, with both valids raised to prove readies are held low.
    #12;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    chk("rst_vld", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_res", rsp_result, 32'd0);
    chk("rst_zero", 32'(rsp_zero), 32'd0);
    chk("rst_neg", 32'(rsp_neg), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Directed ALU vectors.
    do_req("add",   1'b0, 32'd5, 32'd7, F3_ADD, 1'b0, 32'd12, 1'b0, 1'b0);
    do_req("sub",   1'b1, 32'd3, 32'd5, F3_ADD, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    do_req("slt",   1'b0, 32'hFFFF_FFFF, 32'd1, F3_SLT, 1'b0, 32'd1, 1'b0, 1'b0);
    do_req("sltu",  1'b0, 32'hFFFF_FFFF, 32'd1, F3_SLTU, 1'b0, 32'd0, 1'b0, 1'b1);
    do_req("sra",   1'b0, 32'h8000_0000, 32'd4, F3_SR, 1'b1, 32'hF800_0000, 1'b1, 1'b0);
    do_req("srl",   1'b0, 32'h8000_0000, 32'd4, F3_SR, 1'b0, 32'h0800_0000, 1'b0, 1'b0);
    do_req("sll",   1'b1, 32'd1, 32'h0000_003F, F3_SLL, 1'b0, 32'h8000_0000, 1'b1, 1'b0);
    do_req("xor",   1'b1, 32'hA5A5_A5A5, 32'hFFFF_0000, F3_XOR, 1'b0, 32'h5A5A_A5A5, 1'b0, 1'b0);
    do_req("or",    1'b0, 32'h0000_00F0, 32'h0000_000F, F3_OR, 1'b0, 32'h0000_00FF, 1'b0, 1'b0);
    do_req("addwr", 1'b0, 32'hFFFF_FFFF, 32'd1, F3_ADD, 1'b0, 32'd0, 1'b0, 1'b1);

    // Backpressure: response held 5 cycles while both requesters knock.
    drive(1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, F3_AND, 1'b0);
    wait_grant("bp", 1'b0);
    req0_valid = 1'b0;
    tick();
    held_res = rsp_result;
    held_id  = rsp_id;
    chk("bp_res", held_res, 32'hF000_F000);
    drive(1'b0, 32'd1, 32'd1, F3_ADD, 1'b0);
    drive(1'b1, 32'd1, 32'd1, F3_ADD, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_vld", 32'(rsp_valid), 32'd1);
      chk("bp_hold_res", rsp_result, 32'hF000_F000);
      chk("bp_hold_id", 32'(rsp_id), 32'd0);
      chk("bp_rdy_any", 32'(req0_ready | req1_ready), 32'd0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_release", 32'(rsp_valid), 32'd0);

    // Reset during EXEC discards the operation.
    drive(1'b0, 32'd100, 32'd1, F3_ADD, 1'b0);
    wait_grant("rexec", 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rexec_vld", 32'(rsp_valid), 32'd0);
    chk("rexec_rdy", 32'(req0_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rexec_after_vld", 32'(rsp_valid), 32'd0);
    chk("rexec_after_res", rsp_result, 32'd0);
    tick();
    chk("rexec_after_vld2", 32'(rsp_valid), 32'd0);
    do_req("post_rst", 1'b1, 32'd2, 32'd3, F3_ADD, 1'b0, 32'd5, 1'b0, 1'b0);

    // Both requesters valid for 4 ops, starting from a fresh priority pointer.
    pulse_reset();
`ifdef ALU_SCHED_RR_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    seen1 = 1'b0;
    drive(1'b0, 32'd1, 32'd1, F3_ADD, 1'b0);
    drive(1'b1, 32'd10, 32'd10, F3_ADD, 1'b0);
    #1;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      while (!(req0_ready | req1_ready) && n < 20) begin
        tick();
        n++;
      end
      chk("arb_timeout", 32'(n < 20), 32'd1);
      chk("arb_onehot", 32'(req0_ready) + 32'(req1_ready), 32'd1);
      if (req1_ready) seen1 = 1'b1;
      tick();
      tick();
      chk("arb_vld", 32'(rsp_valid), 32'd1);
      chk("arb_id", 32'(rsp_id), 32'(exp_ids[k]));
      chk("arb_res", rsp_result, exp_ids[k] ? 32'd20 : 32'd2);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef ALU_SCHED_RR_EN
    chk("arb_seen1", 32'(seen1), 32'd1);
`else
    chk("arb_seen1", 32'(seen1), 32'd0);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 ns");
    $fatal(1);
  end

endmodule
